// File: rtl/sm_to_twos_serial_if.sv
// rtl/sm_to_twos_serial_if.sv - operand/result handshake bundle for the serial sign-magnitude to two's-complement converter
interface sm_to_twos_serial_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [3:0] in_mag;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_data;
    logic       out_negzero;

    // Producer/consumer side
    modport master (
        output in_valid,
        output in_sign,
        output in_mag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_negzero
    );

    // Converter side
    modport slave (
        input  in_valid,
        input  in_sign,
        input  in_mag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_negzero
    );
endinterface

// File: rtl/sm_to_twos_serial.sv
// rtl/sm_to_twos_serial.sv - bit-serial sign-magnitude to 5-bit two's-complement converter
module sm_to_twos_serial (
    input  logic                  clk,
    input  logic                  rst,
    sm_to_twos_serial_if.slave    bus,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [4:0] shreg;
    logic [4:0] result;
    logic [2:0] cnt;
    logic       sign_q;
    logic       found_one;
    logic       negzero_q;
    logic [4:0] out_data_q;
    logic       out_negzero_q;
    logic       obit;
    logic       in_ready_c;
    logic       out_valid_c;
    logic       busy_c;

    // Negating serially: copy bits up to and including the first 1, invert the rest.
    assign obit = (sign_q & found_one) ? ~shreg[0] : shreg[0];

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == 3'd4) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_c    = 1'b0;
            end
        endcase
    end

    // Operand capture, one bit per SHIFT cycle, and result publication on entry to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg         <= 5'd0;
            result        <= 5'd0;
            cnt           <= 3'd0;
            sign_q        <= 1'b0;
            found_one     <= 1'b0;
            negzero_q     <= 1'b0;
            out_data_q    <= 5'd0;
            out_negzero_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg     <= {1'b0, bus.in_mag};
                        sign_q    <= bus.in_sign;
                        cnt       <= 3'd0;
                        found_one <= 1'b0;
                        negzero_q <= bus.in_sign & (bus.in_mag == 4'd0);
                    end
                end
                SHIFT: begin
                    shreg     <= {1'b0, shreg[4:1]};
                    result    <= {obit, result[4:1]};
                    found_one <= found_one | shreg[0];
                    if (cnt == 3'd4) begin
                        // Counter parks at 4; the visible result only changes here.
                        out_data_q    <= {obit, result[4:1]};
                        out_negzero_q <= negzero_q;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_data    = out_data_q;
    assign bus.out_negzero = out_negzero_q;
    assign busy            = busy_c;

endmodule

// File: tb/tb_sm_to_twos_serial.sv
// tb/tb_sm_to_twos_serial.sv - directed self-checking bench for sm_to_twos_serial
module tb_sm_to_twos_serial;

    logic clk;
    logic rst;
    logic busy;
    int   checks;
    int   failures;

    sm_to_twos_serial_if bus ();

    sm_to_twos_serial dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ref_val(input logic s, input logic [3:0] m);
        return s ? (5'd0 - {1'b0, m}) : {1'b0, m};
    endfunction

    // Present an operand for one accepting edge; edges returns 1 for that edge.
    task automatic accept(input logic s, input logic [3:0] m);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_mag   = m;
        tick();
        bus.in_valid = 1'b0;
        bus.in_sign  = ~s;
        bus.in_mag   = ~m;
    endtask

    // Counts edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic wait_done(output int edges);
        edges = 1;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) break;
            tick();
            edges++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic s, input logic [3:0] m, input logic check_lat);
        int edges;
        accept(s, m);
        wait_done(edges);
        if (check_lat) check({tag, "_lat"}, 8'(edges), 8'd6);
        check({tag, "_valid"}, {7'd0, bus.out_valid}, 8'd1);
        check({tag, "_data"}, {3'd0, bus.out_data}, {3'd0, ref_val(s, m)});
        check({tag, "_nz"}, {7'd0, bus.out_negzero}, {7'd0, s && (m == 4'd0)});
        take();
    endtask

    initial begin
        int        edges;
        int        seen;
        int        idx;
        int        res_idx;
        int        acc_cyc [4];
        logic      acc;
        logic      tk;
        logic      ops_s [4];
        logic [3:0] ops_m [4];
        logic [4:0] exp_d [4];
        logic      exp_nz [4];

        checks        = 0;
        failures      = 0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_mag    = 4'd0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();

        check("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
        check("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_out_data", {3'd0, bus.out_data}, 8'd0);
        check("rst_negzero", {7'd0, bus.out_negzero}, 8'd0);
        rst = 1'b0;
        tick();

        // Hand-computed vectors
        accept(1'b0, 4'd5);
        check("p5_busy", {7'd0, busy}, 8'd1);
        check("p5_in_ready_shift", {7'd0, bus.in_ready}, 8'd0);
        wait_done(edges);
        check("p5_lat", 8'(edges), 8'd6);
        check("p5_data", {3'd0, bus.out_data}, 8'b0000_0101);
        check("p5_nz", {7'd0, bus.out_negzero}, 8'd0);
        take();
        check("p5_idle", {7'd0, bus.in_ready}, 8'd1);

        accept(1'b1, 4'd5);
        wait_done(edges);
        check("m5_data", {3'd0, bus.out_data}, 8'b0001_1011);
        take();
        accept(1'b1, 4'd15);
        wait_done(edges);
        check("m15_data", {3'd0, bus.out_data}, 8'b0001_0001);
        take();
        accept(1'b1, 4'd1);
        wait_done(edges);
        check("m1_data", {3'd0, bus.out_data}, 8'b0001_1111);
        take();
        accept(1'b1, 4'd0);
        wait_done(edges);
        check("m0_data", {3'd0, bus.out_data}, 8'd0);
        check("m0_nz", {7'd0, bus.out_negzero}, 8'd1);
        take();

        // Stall in DONE with stray in_valid pulses
        accept(1'b0, 4'd7);
        wait_done(edges);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_sign  = 1'b1;
            bus.in_mag   = 4'(i);
            tick();
            check("stall_data", {3'd0, bus.out_data}, 8'b0000_0111);
            check("stall_in_ready", {7'd0, bus.in_ready}, 8'd0);
            check("stall_valid", {7'd0, bus.out_valid}, 8'd1);
        end
        bus.in_valid = 1'b0;
        take();
        check("stall_release_ready", {7'd0, bus.in_ready}, 8'd1);
        check("stall_release_valid", {7'd0, bus.out_valid}, 8'd0);

        // Reset during the third SHIFT cycle
        accept(1'b1, 4'd9);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", {7'd0, bus.in_ready}, 8'd1);
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_data", {3'd0, bus.out_data}, 8'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) seen++;
            tick();
        end
        check("abort_no_valid", 8'(seen), 8'd0);
        run_op("p3", 1'b0, 4'd3, 1'b1);
        check("p3_const", {3'd0, ref_val(1'b0, 4'd3)}, 8'b0000_0011);

        // Back-to-back throughput
        ops_s = '{1'b1, 1'b0, 1'b1, 1'b0};
        ops_m = '{4'd6, 4'd9, 4'd0, 4'd15};
        exp_d = '{5'b11010, 5'b01001, 5'b00000, 5'b01111};
        exp_nz = '{1'b0, 1'b0, 1'b1, 1'b0};
        idx     = 0;
        res_idx = 0;
        bus.in_valid  = 1'b1;
        bus.in_sign   = ops_s[0];
        bus.in_mag    = ops_m[0];
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = bus.in_ready && bus.in_valid;
            tk  = bus.out_valid && bus.out_ready;
            if (tk && res_idx < 4) begin
                check("tp_data", {3'd0, bus.out_data}, {3'd0, exp_d[res_idx]});
                check("tp_nz", {7'd0, bus.out_negzero}, {7'd0, exp_nz[res_idx]});
                check("tp_no_accept_on_take", {7'd0, bus.in_ready}, 8'd0);
                res_idx++;
            end
            tick();
            if (acc && idx < 4) begin
                acc_cyc[idx] = cyc;
                idx++;
                if (idx < 4) begin
                    bus.in_sign = ops_s[idx];
                    bus.in_mag  = ops_m[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (res_idx == 4) break;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("tp_results", 8'(res_idx), 8'd4);
        check("tp_accepts", 8'(idx), 8'd4);
        for (int k = 1; k < 4; k++) begin
            check("tp_period", 8'(acc_cyc[k] - acc_cyc[k-1]), 8'd7);
        end
        tick();
        tick();

        // Full sweep against sign ? -mag : mag
        for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 16; m++) begin
                run_op("sweep", s[0], 4'(m), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
